// File: rtl/multi_score_tracker.sv
`default_nettype none
// ============================================================================
// Module      : multi_score_tracker
// Description : Parametrised multi-player score keeper. Counts rising edges
//               on per-player point (increment) and penalty (decrement) lines,
//               declares a winner, or a tie, when a score reaches WIN_SCORE,
//               then freezes play until restarted.
// Ports       : clk       - system clock
//               reset     - asynchronous, active-low reset
//               restart   - synchronous level; back to play, scores zeroed
//               point     - per-player increment event (rising edge counted)
//               penalty   - per-player decrement event (rising edge counted)
//               score     - packed scores, player 0 in [SCORE_W-1:0]
//               game_over - high while the game is over
//               winner    - players that reached WIN_SCORE (multi-hot on tie)
//               tie       - more than one winner bit set
// Revision    : 1.0 - initial release
// ============================================================================
module multi_score_tracker #(
    parameter int NUM_PLAYERS = 2,
    parameter int WIN_SCORE   = 9,
    parameter int SCORE_W     = 4,
    parameter int PENALTY_EN  = 1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           restart,
    input  logic [NUM_PLAYERS-1:0]         point,
    input  logic [NUM_PLAYERS-1:0]         penalty,
    output logic [NUM_PLAYERS*SCORE_W-1:0] score,
    output logic                           game_over,
    output logic [NUM_PLAYERS-1:0]         winner,
    output logic                           tie
);

    // ------------------------------------------------------------------
    // Elaboration-time parameter checks
    // ------------------------------------------------------------------
    generate
        if (NUM_PLAYERS < 1 || NUM_PLAYERS > 8) begin : g_bad_num_players
            $error("multi_score_tracker: NUM_PLAYERS must be in 1..8");
        end
        if (WIN_SCORE < 1 || WIN_SCORE >= (1 << SCORE_W)) begin : g_bad_win_score
            $error("multi_score_tracker: WIN_SCORE must be in 1..2^SCORE_W-1");
        end
    endgenerate

    localparam logic [SCORE_W-1:0]     c_win       = SCORE_W'(WIN_SCORE);
    localparam logic [SCORE_W-1:0]     c_score_one = SCORE_W'(1);
    localparam logic [NUM_PLAYERS-1:0] c_one       = NUM_PLAYERS'(1);
    localparam logic [NUM_PLAYERS-1:0] c_pen_mask  = {NUM_PLAYERS{(PENALTY_EN != 0)}};

    typedef enum logic [0:0] {
        S_PLAY = 1'b0,
        S_OVER = 1'b1
    } state_t;

    state_t                           r_state;
    state_t                           w_state_next;
    logic [NUM_PLAYERS-1:0]           r_point_q;
    logic [NUM_PLAYERS-1:0]           r_penalty_q;
    logic [NUM_PLAYERS*SCORE_W-1:0]   r_score;
    logic [NUM_PLAYERS-1:0]           r_winner;
    logic                             r_tie;

    logic [NUM_PLAYERS-1:0]           w_inc;
    logic [NUM_PLAYERS-1:0]           w_dec;
    logic [NUM_PLAYERS*SCORE_W-1:0]   w_next_score;
    logic [NUM_PLAYERS-1:0]           w_hit;
    logic                             w_any_hit;
    logic                             w_tie;

    // Rising-edge detection; history registers run in every state so an
    // event held through OVER or restart never re-fires later.
    assign w_inc = point & ~r_point_q;
    assign w_dec = penalty & ~r_penalty_q & c_pen_mask;

    // Candidate scores for the PLAY state and the win check on them.
    always_comb begin
        w_next_score = r_score;
        w_hit        = '0;
        for (int i = 0; i < NUM_PLAYERS; i++) begin
            if (w_inc[i] && !w_dec[i]) begin
                w_next_score[i*SCORE_W +: SCORE_W] = r_score[i*SCORE_W +: SCORE_W] + c_score_one;
            end else if (w_dec[i] && !w_inc[i] && (r_score[i*SCORE_W +: SCORE_W] != '0)) begin
                w_next_score[i*SCORE_W +: SCORE_W] = r_score[i*SCORE_W +: SCORE_W] - c_score_one;
            end
            w_hit[i] = (w_next_score[i*SCORE_W +: SCORE_W] == c_win);
        end
    end

    assign w_any_hit = |w_hit;
    // Clearing the lowest set bit leaves something only if two or more were set.
    assign w_tie     = ((w_hit & (w_hit - c_one)) != '0);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        if (restart) begin
            w_state_next = S_PLAY;
        end else begin
            case (r_state)
                S_PLAY:  if (w_any_hit) w_state_next = S_OVER;
                S_OVER:  w_state_next = S_OVER;
                default: w_state_next = S_PLAY;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // State and data registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_PLAY;
            r_point_q   <= '0;
            r_penalty_q <= '0;
            r_score     <= '0;
            r_winner    <= '0;
            r_tie       <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_point_q   <= point;
            r_penalty_q <= penalty;
            if (restart) begin
                r_score  <= '0;
                r_winner <= '0;
                r_tie    <= 1'b0;
            end else if (r_state == S_PLAY) begin
                r_score <= w_next_score;
                if (w_any_hit) begin
                    r_winner <= w_hit;
                    r_tie    <= w_tie;
                end
            end
        end
    end

    assign score     = r_score;
    assign game_over = (r_state == S_OVER);
    assign winner    = r_winner;
    assign tie       = r_tie;

endmodule
`default_nettype wire

// File: tb/tb_multi_score_tracker.sv
`default_nettype none
// ============================================================================
// Module      : tb_multi_score_tracker
// Description : Self-checking bench for multi_score_tracker. Two instances:
//               a default 2-player game and a 4-player, 5-bit, win-at-20
//               game with penalties disabled. A behavioural game model
//               produces expected outputs into a queue; a negedge monitor
//               pops and compares them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multi_score_tracker;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        restart = 1'b0;
    logic [1:0]  pt0 = '0, pn0 = '0;
    logic [3:0]  pt1 = '0, pn1 = '0;
    logic [7:0]  sc0;
    logic [19:0] sc1;
    logic        go0, go1, tie0, tie1;
    logic [1:0]  w0;
    logic [3:0]  w1;

    always #5 clk = ~clk;

    multi_score_tracker u_dut0 (
        .clk(clk), .reset(reset), .restart(restart),
        .point(pt0), .penalty(pn0),
        .score(sc0), .game_over(go0), .winner(w0), .tie(tie0)
    );

    multi_score_tracker #(
        .NUM_PLAYERS(4), .WIN_SCORE(20), .SCORE_W(5), .PENALTY_EN(0)
    ) u_dut1 (
        .clk(clk), .reset(reset), .restart(restart),
        .point(pt1), .penalty(pn1),
        .score(sc1), .game_over(go1), .winner(w1), .tie(tie1)
    );

    // ---------------- behavioural model ----------------
    int cfg_n   [2] = '{2, 4};
    int cfg_win [2] = '{9, 20};
    int cfg_sw  [2] = '{4, 5};
    int cfg_pen [2] = '{1, 0};

    int         m_score [2][8];
    logic [7:0] m_pq [2];
    logic [7:0] m_nq [2];
    bit         m_over [2];
    logic [7:0] m_win [2];
    bit         m_tie [2];

    typedef struct packed {
        logic [31:0] s0;
        logic [31:0] s1;
        logic        go0;
        logic        go1;
        logic [7:0]  w0;
        logic [7:0]  w1;
        logic        t0;
        logic        t1;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   passed = 0;

    function automatic void model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 8; i++) m_score[d][i] = 0;
            m_pq[d] = '0; m_nq[d] = '0;
            m_over[d] = 1'b0; m_win[d] = '0; m_tie[d] = 1'b0;
        end
    endfunction

    function automatic void model_step(int d, logic [7:0] p, logic [7:0] n, bit rs);
        logic [7:0] inc, dec, hits;
        inc = p & ~m_pq[d];
        dec = (cfg_pen[d] != 0) ? (n & ~m_nq[d]) : 8'h00;
        m_pq[d] = p;
        m_nq[d] = n;
        if (rs) begin
            for (int i = 0; i < 8; i++) m_score[d][i] = 0;
            m_over[d] = 1'b0; m_win[d] = '0; m_tie[d] = 1'b0;
        end else if (!m_over[d]) begin
            hits = '0;
            for (int i = 0; i < cfg_n[d]; i++) begin
                if (inc[i] && !dec[i]) m_score[d][i] = m_score[d][i] + 1;
                else if (dec[i] && !inc[i] && m_score[d][i] > 0) m_score[d][i] = m_score[d][i] - 1;
                if (m_score[d][i] == cfg_win[d]) hits[i] = 1'b1;
            end
            if (hits != 0) begin
                m_over[d] = 1'b1;
                m_win[d]  = hits;
                m_tie[d]  = ($countones(hits) > 1);
            end
        end
    endfunction

    function automatic logic [31:0] pack_score(int d);
        logic [31:0] s;
        s = '0;
        for (int i = 0; i < cfg_n[d]; i++) s = s | (32'(m_score[d][i]) << (i * cfg_sw[d]));
        return s;
    endfunction

    // ---------------- stimulus ----------------
    // Inputs change 1 time unit after the rising edge. Expected values
    // pushed here are what the monitor must see at the following negedge.
    task automatic cyc(input logic rst_v, input logic rs,
                       input logic [1:0] a_pt, input logic [1:0] a_pn,
                       input logic [3:0] b_pt, input logic [3:0] b_pn);
        exp_t e;
        @(posedge clk);
        #1;
        reset = rst_v; restart = rs;
        pt0 = a_pt; pn0 = a_pn; pt1 = b_pt; pn1 = b_pn;
        if (!rst_v) model_reset();
        e.s0 = pack_score(0);   e.s1 = pack_score(1);
        e.go0 = m_over[0];      e.go1 = m_over[1];
        e.w0 = m_win[0];        e.w1 = m_win[1];
        e.t0 = m_tie[0];        e.t1 = m_tie[1];
        exp_q.push_back(e);
        if (rst_v) begin
            model_step(0, {6'b0, a_pt}, {6'b0, a_pn}, rs);
            model_step(1, {4'b0, b_pt}, {4'b0, b_pn}, rs);
        end
    endtask

    task automatic pulse0(input logic [1:0] p, input logic [1:0] n);
        cyc(1'b1, 1'b0, p, n, 4'b0, 4'b0);
        cyc(1'b1, 1'b0, 2'b0, 2'b0, 4'b0, 4'b0);
    endtask

    // ---------------- monitor ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("score0",     32'(sc0),  e.s0);
            chk("game_over0", 32'(go0),  32'(e.go0));
            chk("winner0",    32'(w0),   32'(e.w0));
            chk("tie0",       32'(tie0), 32'(e.t0));
            chk("score1",     32'(sc1),  e.s1);
            chk("game_over1", 32'(go1),  32'(e.go1));
            chk("winner1",    32'(w1),   32'(e.w1));
            chk("tie1",       32'(tie1), 32'(e.t1));
        end
    end

    initial begin
        model_reset();
        cyc(1'b0, 1'b0, 2'b0, 2'b0, 4'b0, 4'b0);
        cyc(1'b0, 1'b0, 2'b0, 2'b0, 4'b0, 4'b0);

        // Reset mid-game with point[0] held high through release
        repeat (5) pulse0(2'b01, 2'b00);
        repeat (3) pulse0(2'b10, 2'b00);
        cyc(1'b0, 1'b0, 2'b01, 2'b0, 4'b0, 4'b0);
        cyc(1'b0, 1'b0, 2'b01, 2'b0, 4'b0, 4'b0);
        cyc(1'b1, 1'b0, 2'b01, 2'b0, 4'b0, 4'b0);
        cyc(1'b1, 1'b0, 2'b01, 2'b0, 4'b0, 4'b0);
        cyc(1'b1, 1'b0, 2'b00, 2'b0, 4'b0, 4'b0);

        // Single win for player 1, then extra pulses while over
        cyc(1'b1, 1'b1, 2'b0, 2'b0, 4'b0, 4'b0);
        repeat (11) pulse0(2'b10, 2'b00);

        // Penalties, saturation, simultaneous point and penalty
        cyc(1'b1, 1'b1, 2'b0, 2'b0, 4'b0, 4'b0);
        repeat (2) pulse0(2'b01, 2'b00);
        repeat (3) pulse0(2'b00, 2'b01);
        pulse0(2'b01, 2'b01);
        pulse0(2'b01, 2'b00);
        pulse0(2'b01, 2'b01);

        // Tie
        cyc(1'b1, 1'b1, 2'b0, 2'b0, 4'b0, 4'b0);
        repeat (9) pulse0(2'b11, 2'b00);

        // Restart together with a point edge, then restart held
        cyc(1'b1, 1'b1, 2'b01, 2'b0, 4'b0, 4'b0);
        cyc(1'b1, 1'b1, 2'b00, 2'b0, 4'b0, 4'b0);
        cyc(1'b1, 1'b1, 2'b10, 2'b0, 4'b0, 4'b0);
        cyc(1'b1, 1'b1, 2'b00, 2'b0, 4'b0, 4'b0);
        cyc(1'b1, 1'b0, 2'b00, 2'b0, 4'b0, 4'b0);

        // Wide instance: player 3 to 20, penalties disabled
        cyc(1'b1, 1'b1, 2'b0, 2'b0, 4'b0, 4'b0);
        repeat (22) begin
            cyc(1'b1, 1'b0, 2'b0, 2'b0, 4'b1000, 4'b1111);
            cyc(1'b1, 1'b0, 2'b0, 2'b0, 4'b0000, 4'b0000);
        end

        // Randomized play on both instances
        cyc(1'b1, 1'b1, 2'b0, 2'b0, 4'b0, 4'b0);
        repeat (500) begin
            cyc(($urandom_range(0, 199) != 0), ($urandom_range(0, 39) == 0),
                2'($urandom), 2'($urandom & $urandom),
                4'($urandom), 4'($urandom));
        end
        cyc(1'b1, 1'b0, 2'b0, 2'b0, 4'b0, 4'b0);

        // Drain with a bounded wait
        for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk);
        checks++;
        if (exp_q.size() == 0) passed++;
        else $display("FAIL drain: got %0d pending expected 0", exp_q.size());

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
`default_nettype wire
